bias_add_pipe: RTL and testbench

Parametrised bias stage that follows the adder trees of a convolution layer. It holds a runtime-loadable bias table of `N_GROUPS` groups × `N_LANES` lanes. Each accepted accumulator vector gets the current group's biases added lane-wise, with saturation, and the group pointer then advances with wrap-around. It replaces the per-layer hard-wired constant bias blocks with one reusable, streaming block.

---
 rtl/bias_pkg.sv | 14 +
 rtl/bias_add_pipe_if.sv | 24 ++
 rtl/bias_sat_lane.sv | 42 ++++
 rtl/bias_add_pipe.sv | 116 +++++++++++
 tb/tb_bias_add_pipe.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bias_pkg.sv
// Shared constants and helpers for the bias-add pipeline.
// Optional feature macro: BIAS_ADD_RELU_EN (fused ReLU in the lane stage).
package bias_pkg;
  localparam int DATA_W_DEF = 18;

  // Clamp limits for the default data width
  localparam logic signed [DATA_W_DEF-1:0] sat_max = {1'b0, {(DATA_W_DEF-1){1'b1}}};
  localparam logic signed [DATA_W_DEF-1:0] sat_min = {1'b1, {(DATA_W_DEF-1){1'b0}}};

  // Low bit of a lane within a flattened lane bus (lane 0 at the LSBs)
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction
endpackage

// File: rtl/bias_add_pipe_if.sv
// Streaming in/out handshake bundle for bias_add_pipe.
interface bias_add_pipe_if #(
  parameter int N_LANES = 16,
  parameter int DATA_W  = 18,
  parameter int GRP_W   = 3
);
  logic                        in_valid;
  logic                        in_ready;
  logic [N_LANES*DATA_W-1:0]   in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [N_LANES*DATA_W-1:0]   out_data;
  logic [GRP_W-1:0]            out_grp;
  logic                        out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_grp, out_last
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_grp, out_last
  );
endinterface

// File: rtl/bias_sat_lane.sv
// One lane of stage 2: add bias, clamp to DATA_W, optional ReLU, register.
// Optional feature macro: BIAS_ADD_RELU_EN.
module bias_sat_lane
  import bias_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              clamp
);
  // Package constants cover the default width; other widths build their own
  localparam logic [DATA_W-1:0] SMAX = (DATA_W == DATA_W_DEF) ? DATA_W'(sat_max)
                                                               : {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = (DATA_W == DATA_W_DEF) ? DATA_W'(sat_min)
                                                               : {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] res;

  // Sign-extended add; overflow shows as the top two sum bits disagreeing
  always_comb begin
    sum   = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    clamp = sum[DATA_W] ^ sum[DATA_W-1];
    res   = sum[DATA_W-1:0];
    if (clamp) res = sum[DATA_W] ? SMIN : SMAX;
`ifdef BIAS_ADD_RELU_EN
    // ReLU after clamping, so clamp still reports the signed overflow
    if (res[DATA_W-1]) res = '0;
`endif
  end

  // Result register, advances only with a valid stage-1 entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  y <= '0;
    else if (en) y <= res;
  end
endmodule

// File: rtl/bias_add_pipe.sv
// Streaming bias stage: runtime bias table, wrapping group pointer,
// 2-stage pipeline with lane-wise saturating add and sticky sat flag.
// Optional feature macro: BIAS_ADD_RELU_EN (handled in bias_sat_lane).
module bias_add_pipe
  import bias_pkg::*;
#(
  parameter int N_LANES  = 16,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int N_GROUPS = 8,
  parameter int GRP_W    = $clog2(N_GROUPS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [GRP_W-1:0]           cfg_last,
  input  logic                       ld_en,
  input  logic [GRP_W-1:0]           ld_grp,
  input  logic [$clog2(N_LANES)-1:0] ld_lane,
  input  logic [DATA_W-1:0]          ld_data,
  bias_add_pipe_if.slave             bus,
  output logic                       sat_flag
);
  localparam int STAGES = 2;
  localparam int VW     = N_LANES * DATA_W;

  logic [N_GROUPS-1:0][N_LANES-1:0][DATA_W-1:0] tbl;
  logic [STAGES:1]    vld_pipe;
  logic [GRP_W-1:0]   grp, grp_use, last_eff;
  logic               en, accept, ld_ok, sat_set;
  logic [VW-1:0]      s1_data, s1_bias;
  logic [GRP_W-1:0]   s1_grp, o_grp;
  logic               s1_last, o_last;
  logic [N_LANES-1:0] clamp;

  assign en            = !vld_pipe[STAGES] || bus.out_ready;
  assign accept        = bus.in_valid && en;
  assign bus.in_ready  = en;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.out_grp   = o_grp;
  assign bus.out_last  = o_last;
  assign sat_set       = en && vld_pipe[1] && (|clamp);

  // Out-of-range config is clamped; start forces the group used this cycle to 0
  always_comb begin
    last_eff = cfg_last;
    if ({1'b0, cfg_last} > (GRP_W+1)'(N_GROUPS-1)) last_eff = GRP_W'(N_GROUPS-1);
    grp_use = start ? '0 : grp;
    ld_ok   = ({1'b0, ld_grp} <= (GRP_W+1)'(N_GROUPS-1));
  end

  // Bias table writes; a same-cycle fetch sees the pre-write value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tbl <= '0;
    else if (ld_en && ld_ok) tbl[ld_grp][ld_lane] <= ld_data;
  end

  // Group pointer: advance with wrap on accept, start rewinds to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      grp <= '0;
    else if (accept) grp <= (grp_use == last_eff) ? '0 : grp_use + GRP_W'(1);
    else if (start)  grp <= '0;
  end

  // Stage 1: capture vector, bias row and group tag on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      s1_data     <= '0;
      s1_bias     <= '0;
      s1_grp      <= '0;
      s1_last     <= 1'b0;
    end else if (en) begin
      vld_pipe[1] <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data <= bus.in_data;
        s1_bias <= tbl[grp_use];
        s1_grp  <= grp_use;
        s1_last <= (grp_use == last_eff);
      end
    end
  end

  // Stage 2 control: valid and group tag travel alongside the lane results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES] <= 1'b0;
      o_grp            <= '0;
      o_last           <= 1'b0;
    end else if (en) begin
      vld_pipe[STAGES] <= vld_pipe[1];
      if (vld_pipe[1]) begin
        o_grp  <= s1_grp;
        o_last <= s1_last;
      end
    end
  end

  // Sticky clamp flag; a clamp in the same cycle as start keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sat_flag <= 1'b0;
    else if (sat_set) sat_flag <= 1'b1;
    else if (start)   sat_flag <= 1'b0;
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    bias_sat_lane #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en && vld_pipe[1]),
      .a     (s1_data[lane_lo(i, DATA_W) +: DATA_W]),
      .b     (s1_bias[lane_lo(i, DATA_W) +: DATA_W]),
      .y     (bus.out_data[lane_lo(i, DATA_W) +: DATA_W]),
      .clamp (clamp[i])
    );
  end
endmodule

// File: tb/tb_bias_add_pipe.sv
// Directed self-checking bench for bias_add_pipe.
// Expected values follow BIAS_ADD_RELU_EN when it is defined for the build.
module tb_bias_add_pipe;
  localparam int NL = 16;
  localparam int DW = 18;
  localparam int GW = 3;
  localparam int VW = NL * DW;

  logic          clk = 0;
  logic          rst_n, start, ld_en, sat_flag;
  logic [GW-1:0] cfg_last, ld_grp;
  logic [3:0]    ld_lane;
  logic [DW-1:0] ld_data;
  int            n_cmp = 0;
  int            n_err = 0;

  logic [VW-1:0] q_d[$];
  logic [GW-1:0] q_g[$];
  logic          q_l[$];

  bias_add_pipe_if #(.N_LANES(NL), .DATA_W(DW), .GRP_W(GW)) bus ();

  bias_add_pipe dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_last(cfg_last),
    .ld_en(ld_en), .ld_grp(ld_grp), .ld_lane(ld_lane), .ld_data(ld_data),
    .bus(bus), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  // Output transfers, sampled mid-cycle
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      q_d.push_back(bus.out_data);
      q_g.push_back(bus.out_grp);
      q_l.push_back(bus.out_last);
    end

  function automatic int eo(input int x);
`ifdef BIAS_ADD_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [VW-1:0] mk(input int lane, input int val);
    logic [VW-1:0] v;
    v = '0;
    v[lane*DW +: DW] = DW'(val);
    return v;
  endfunction

  function automatic logic [DW-1:0] lane_of(input logic [VW-1:0] v, input int lane);
    return v[lane*DW +: DW];
  endfunction

  task automatic clr_q();
    q_d.delete(); q_g.delete(); q_l.delete();
  endtask

  task automatic ld(input int g, input int l, input int v);
    ld_en = 1; ld_grp = GW'(g); ld_lane = 4'(l); ld_data = DW'(v);
    @(posedge clk); #1;
    ld_en = 0;
  endtask

  task automatic do_start();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic send(input logic [VW-1:0] d, input logic st);
    bit acc;
    acc = 0;
    bus.in_valid = 1; bus.in_data = d; start = st;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 0; start = 0;
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready never seen high");
    end
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 50 && q_d.size() < n; i++) @(posedge clk);
    #1;
    n_cmp++;
    if (q_d.size() < n) begin
      n_err++;
      $display("FAIL wait_out: got %0d outputs, required %0d", q_d.size(), n);
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== '0) begin n_err++; $display("FAIL rst_out_data got %h exp 0", bus.out_data); end
    n_cmp++; if (bus.out_grp !== '0) begin n_err++; $display("FAIL rst_out_grp got %0d exp 0", bus.out_grp); end
    n_cmp++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last got %b exp 0", bus.out_last); end
    n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL rst_sat_flag got %b exp 0", sat_flag); end
    @(posedge clk); #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_load_stream();
    int ed[3] = '{105, -35, 105};
    int eg[3] = '{0, 1, 0};
    int el[3] = '{0, 1, 0};
    ld(0, 0, 100); ld(1, 0, -40);
    cfg_last = 1; do_start(); clr_q();
    repeat (3) send(mk(0, 5), 0);
    wait_out(3);
    for (int i = 0; i < 3 && i < q_d.size(); i++) begin
      n_cmp++;
      if (lane_of(q_d[i], 0) !== DW'(eo(ed[i]))) begin
        n_err++; $display("FAIL stream_data[%0d] got %0d exp %0d", i, $signed(lane_of(q_d[i], 0)), eo(ed[i]));
      end
      n_cmp++;
      if (q_g[i] !== GW'(eg[i])) begin n_err++; $display("FAIL stream_grp[%0d] got %0d exp %0d", i, q_g[i], eg[i]); end
      n_cmp++;
      if (q_l[i] !== 1'(el[i])) begin n_err++; $display("FAIL stream_last[%0d] got %b exp %0d", i, q_l[i], el[i]); end
    end
  endtask

  task automatic test_saturation();
    ld(2, 0, 131000); ld(3, 0, -131000);
    cfg_last = 3; do_start(); clr_q();
    n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_pre got %b exp 0", sat_flag); end
    send(mk(0, 0), 0); send(mk(0, 0), 0); send(mk(0, 1000), 0); send(mk(0, -1000), 0);
    wait_out(4);
    if (q_d.size() >= 4) begin
      n_cmp++;
      if (lane_of(q_d[2], 0) !== DW'(eo(131071))) begin
        n_err++; $display("FAIL sat_hi got %0d exp %0d", $signed(lane_of(q_d[2], 0)), eo(131071));
      end
      n_cmp++;
      if (lane_of(q_d[3], 0) !== DW'(eo(-131072))) begin
        n_err++; $display("FAIL sat_lo got %0d exp %0d", $signed(lane_of(q_d[3], 0)), eo(-131072));
      end
    end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_sticky got %b exp 1", sat_flag); end
    do_start();
    n_cmp++; if (sat_flag !== 1'b0) begin n_err++; $display("FAIL sat_clear got %b exp 0", sat_flag); end
  endtask

  task automatic test_sat_start_collision();
    ld(0, 4, 131000);
    cfg_last = 0; do_start(); clr_q();
    send(mk(4, 1000), 0);
    do_start();
    n_cmp++; if (sat_flag !== 1'b1) begin n_err++; $display("FAIL sat_vs_start got %b exp 1", sat_flag); end
    wait_out(1);
    if (q_d.size() >= 1) begin
      n_cmp++;
      if (lane_of(q_d[0], 4) !== DW'(131071)) begin
        n_err++; $display("FAIL sat_vs_start_data got %0d exp 131071", $signed(lane_of(q_d[0], 4)));
      end
    end
    do_start();
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] held;
    bit have, saw_low;
    have = 0; saw_low = 0; held = '0;
    cfg_last = 3; do_start(); clr_q();
    bus.out_ready = 0;
    fork
      begin
        send(mk(1, 1), 0); send(mk(1, 2), 0); send(mk(1, 3), 0);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          if (!bus.in_ready) saw_low = 1;
          if (bus.out_valid) begin
            if (!have) begin held = bus.out_data; have = 1; end
            else begin
              n_cmp++;
              if (bus.out_data !== held) begin n_err++; $display("FAIL bp_hold got %h exp %h", bus.out_data, held); end
            end
          end
        end
        @(posedge clk); #1;
        bus.out_ready = 1;
      end
    join
    n_cmp++; if (saw_low !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_drop got %b exp 1", saw_low); end
    n_cmp++; if (lane_of(held, 1) !== DW'(1)) begin n_err++; $display("FAIL bp_held_value got %0d exp 1", lane_of(held, 1)); end
    wait_out(3);
    repeat (5) @(posedge clk); #1;
    n_cmp++; if (q_d.size() !== 3) begin n_err++; $display("FAIL bp_count got %0d exp 3", q_d.size()); end
    for (int i = 0; i < 3 && i < q_d.size(); i++) begin
      n_cmp++;
      if (lane_of(q_d[i], 1) !== DW'(i + 1)) begin n_err++; $display("FAIL bp_data[%0d] got %0d exp %0d", i, lane_of(q_d[i], 1), i + 1); end
      n_cmp++;
      if (q_g[i] !== GW'(i)) begin n_err++; $display("FAIL bp_grp[%0d] got %0d exp %0d", i, q_g[i], i); end
    end
  endtask

  task automatic test_start_collision();
    int ed[3] = '{7, 7, 20};
    int eg[3] = '{0, 0, 1};
    ld(0, 2, 7); ld(1, 2, 20);
    cfg_last = 3; do_start(); clr_q();
    send(mk(2, 0), 0);
    send(mk(2, 0), 1);
    send(mk(2, 0), 0);
    wait_out(3);
    for (int i = 0; i < 3 && i < q_d.size(); i++) begin
      n_cmp++;
      if (q_g[i] !== GW'(eg[i])) begin n_err++; $display("FAIL coll_grp[%0d] got %0d exp %0d", i, q_g[i], eg[i]); end
      n_cmp++;
      if (lane_of(q_d[i], 2) !== DW'(ed[i])) begin n_err++; $display("FAIL coll_data[%0d] got %0d exp %0d", i, lane_of(q_d[i], 2), ed[i]); end
    end
  endtask

  task automatic test_relu_fetch();
    int ed[3] = '{-40, 110, 130};
    ld(0, 3, 10);
    cfg_last = 0; do_start(); clr_q();
    send(mk(3, -50), 0);
    ld_en = 1; ld_grp = 0; ld_lane = 3; ld_data = DW'(30);
    send(mk(3, 100), 0);
    ld_en = 0;
    send(mk(3, 100), 0);
    wait_out(3);
    for (int i = 0; i < 3 && i < q_d.size(); i++) begin
      n_cmp++;
      if (lane_of(q_d[i], 3) !== DW'(eo(ed[i]))) begin
        n_err++; $display("FAIL relu_fetch_data[%0d] got %0d exp %0d", i, $signed(lane_of(q_d[i], 3)), eo(ed[i]));
      end
      n_cmp++;
      if (q_g[i] !== '0 || q_l[i] !== 1'b1) begin
        n_err++; $display("FAIL relu_fetch_tag[%0d] got grp %0d last %b exp grp 0 last 1", i, q_g[i], q_l[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    cfg_last = 3; do_start(); clr_q();
    send(mk(0, 5), 0); send(mk(0, 6), 0);
    rst_n = 0; #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid got %b exp 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== '0) begin n_err++; $display("FAIL midrst_out_data got %h exp 0", bus.out_data); end
    repeat (2) @(posedge clk); #1;
    rst_n = 1; clr_q();
    send(mk(0, 5), 0);
    wait_out(1);
    if (q_d.size() >= 1) begin
      n_cmp++;
      if (lane_of(q_d[0], 0) !== DW'(5)) begin n_err++; $display("FAIL midrst_table got %0d exp 5", lane_of(q_d[0], 0)); end
      n_cmp++;
      if (q_g[0] !== '0) begin n_err++; $display("FAIL midrst_grp got %0d exp 0", q_g[0]); end
    end
    repeat (3) @(posedge clk); #1;
    n_cmp++; if (q_d.size() !== 1) begin n_err++; $display("FAIL midrst_flushed got %0d outputs exp 1", q_d.size()); end
  endtask

  initial begin
    rst_n = 0; start = 0; cfg_last = 0; ld_en = 0; ld_grp = 0; ld_lane = 0; ld_data = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 1;
    repeat (2) @(posedge clk); #1;
    rst_n = 1;
    test_reset();
    test_load_stream();
    test_saturation();
    test_sat_start_collision();
    test_backpressure();
    test_start_collision();
    test_relu_fetch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
